prbs_stream_checker: RTL and testbench
======================================

# prbs_stream_checker

Synthesizable consumer stage that sits directly downstream of the device under test in our benches. It accepts a WIDTH-bit word stream over a valid/ready handshake and locks onto a PRBS7 sequence. After lock it compares every word against an internal predictor and reports a saturating error count plus a final pass/fail flag. It replaces hand-written verifier logic for serial and stream outputs, and is reusable on hardware.

## Interface
- WIDTH, 8: data word width; must be ≥ 7 (elaboration error otherwise).
- SYNC_LEN, 4: consecutive correct predictions required to lock.
- NUM_WORDS, 256: words checked after lock before finishing.
- ERR_W, 16: error counter width.

Ports (clock and reset first):
- i_clk  in  1  single clock; all logic on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle start/restart pulse.
- i_valid  in  1  upstream word valid.
- i_data  in  WIDTH  upstream word.
- o_ready  out  1  checker accepts a word when i_valid && o_ready.
- o_locked  out  1  high in CHECK and DONE.
- o_done  out  1  high in DONE.
- o_pass  out  1  high in DONE when o_err_count == 0.
- o_err_count  out  ERR_W  mismatches since lock; saturates at all-ones.
- o_word_count  out  16  words accepted in CHECK.

## Operation
- Predictor is the PRBS7 polynomial x^7+x^6+1 with state s[6:0].
  - Bit step: b = s[6]^s[5]; s <= {s[5:0], b}.
  - One word = WIDTH bit steps; the first generated bit is word[WIDTH-1].
  - After a word, s == word[6:0]. This lets the checker seed itself from received data.
- FSM states: IDLE, SYNC, CHECK, DONE.
- IDLE:
  - o_ready = 0.
  - i_start → SYNC; clears the counters and the sync counter.
- SYNC:
  - o_ready = 1.
  - On each accepted word, compare it with the prediction from the current state.
  - Match: sync_cnt++.
  - Mismatch: sync_cnt = 0.
  - The state is then always reloaded from i_data[6:0].
  - Exception: if i_data[6:0] == 0, the word counts as a mismatch and the state is not loaded (avoids lock-up).
  - The first word after entering SYNC is never a match, because there is no valid prediction yet.
  - When sync_cnt reaches SYNC_LEN → CHECK. Sync words are not counted in o_word_count.
- CHECK:
  - o_ready = 1.
  - Each accepted word: word_count++.
  - Mismatch: err_count++ (saturating).
  - The predictor always advances from its own state; there is no resync on error.
  - When the NUM_WORDS-th word is accepted → DONE.
- DONE:
  - o_ready = 0; the counters hold.
  - i_start → SYNC (new run).
- i_start in SYNC or CHECK: immediate restart into SYNC; counters cleared and the accepted word in that cycle is ignored.
- i_valid without o_ready: no effect. i_data is ignored whenever no transfer occurs.

## Timing
- All outputs are registered.
- Reset values: o_ready 0, o_locked 0, o_done 0, o_pass 0, o_err_count 0, o_word_count 0. State IDLE, predictor state 7'h7F.
- An accept on edge N updates the counters and state, visible at edge N+1 outputs (1-cycle latency).
- o_ready rises 1 cycle after i_start. Words may be accepted on consecutive cycles (full throughput).
- The edge that accepts the final word sets o_done and o_pass and clears o_ready together. No extra word is accepted.
- o_err_count saturates: further mismatches leave it at all-ones.
- o_word_count wraps at 2^16; NUM_WORDS must be < 2^16.
- Reset asserted mid-run forces every reset value immediately (asynchronous). Behaviour resumes from IDLE after deassertion.

## Structure
- Shared package prbs_pkg holds:
  - the state enum typedef (checker_state_t);
  - PRBS7 tap constants;
  - the function prbs7_next_word(state, width).
- One sub-module, lfsr_word_predictor. It is combinational: it takes state in and gives the predicted word out.
- The FSM, counters and handshake stay in prbs_stream_checker.

## Test plan
- Reset then start; send 8'hFF, 8'h02, 8'h0C, then the next golden PRBS7 words with i_valid held high → o_locked rises after SYNC_LEN matches; after 256 correct words o_done=1, o_pass=1, o_err_count=0, o_word_count=256.
- Same stream with word 10 of CHECK flipped to ~expected → o_err_count=1, o_pass=0 at done; the following words still match with no resync.
- In SYNC, inject 8'h80 (low bits zero), then a valid stream → no lock until 4 fresh matches occur after a good seed; o_locked stays 0 in between.
- i_valid toggled every other cycle with random gaps → identical final counts to the back-to-back case; no word accepted while o_ready=0.
- ERR_W=4, all-garbage stream in CHECK → o_err_count saturates at 15.
- Assert i_reset mid-CHECK → all outputs 0 the same cycle; i_start after release → fresh lock and pass.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types and PRBS7 (x^7 + x^6 + 1) helpers for the stream checker.
// prbs7_next_word generates one word MSB-first, so the trailing 7 bits are the next state.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CHECK,
    ST_DONE
  } checker_state_t;

  localparam int         PRBS_TAP_A = 6;
  localparam int         PRBS_TAP_B = 5;
  localparam logic [6:0] PRBS_SEED  = 7'h7F;
  localparam int         MAX_WIDTH  = 64;

  function automatic logic [MAX_WIDTH-1:0] prbs7_next_word(input logic [6:0] state,
                                                          input int width);
    logic [6:0]           s;
    logic [MAX_WIDTH-1:0] word;
    logic                 b;
    s    = state;
    word = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) begin
        b    = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
        s    = {s[5:0], b};
        word = {word[MAX_WIDTH-2:0], b};
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/lfsr_word_predictor.sv
// Combinational PRBS7 word predictor: the next WIDTH-bit word expected after state.
module lfsr_word_predictor
  import prbs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [6:0]       i_state,
  output logic [WIDTH-1:0] o_word
);

  if (WIDTH < 7 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_word_predictor: WIDTH must be in 7..64");
  end

  always_comb begin
    o_word = WIDTH'(prbs7_next_word(i_state, WIDTH));
  end

endmodule

// File: rtl/prbs_stream_checker.sv
// PRBS7 stream checker: seeds from received words until SYNC_LEN consecutive predictions hit,
// then checks NUM_WORDS words against its free-running predictor and reports errors/pass.
module prbs_stream_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SYNC_LEN  = 4,
  parameter int NUM_WORDS = 256,
  parameter int ERR_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_locked,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic [15:0]      o_word_count,
  output checker_state_t   o_dbg_state
);

  if (WIDTH < 7) begin : g_bad_width
    $error("prbs_stream_checker: WIDTH must be >= 7");
  end
  if (SYNC_LEN < 1 || NUM_WORDS < 1 || NUM_WORDS >= 65536) begin : g_bad_len
    $error("prbs_stream_checker: SYNC_LEN >= 1 and 1 <= NUM_WORDS < 65536 required");
  end

  localparam int              SC_W        = $clog2(SYNC_LEN + 1);
  localparam logic [SC_W-1:0] SYNC_LEN_C  = SC_W'(SYNC_LEN);
  localparam logic [15:0]     NUM_WORDS_C = 16'(NUM_WORDS);

  checker_state_t   state_q, state_d;
  logic [6:0]       pred_state_q, pred_state_d;
  logic             have_pred_q, have_pred_d;
  logic [SC_W-1:0]  sync_cnt_q, sync_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [15:0]      word_count_q, word_count_d;
  logic             ready_q, ready_d;
  logic             locked_q, locked_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] pred_word;
  logic             accept;
  logic             word_match;
  logic             seed_zero;

  lfsr_word_predictor #(.WIDTH(WIDTH)) u_pred (
    .i_state (pred_state_q),
    .o_word  (pred_word)
  );

  // Handshake: a word transfers on a rising edge where i_valid && o_ready; nothing else samples i_data.
  assign accept     = i_valid && ready_q;
  assign word_match = (i_data == pred_word);
  assign seed_zero  = (i_data[6:0] == 7'd0);

  always_comb begin
    state_d      = state_q;
    pred_state_d = pred_state_q;
    have_pred_d  = have_pred_q;
    sync_cnt_d   = sync_cnt_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    ready_d      = ready_q;
    locked_d     = locked_q;
    done_d       = done_q;
    pass_d       = pass_q;

    if (i_start) begin
      // Start wins in every state; a word offered in the same cycle is dropped.
      state_d      = ST_SYNC;
      pred_state_d = PRBS_SEED;
      have_pred_d  = 1'b0;
      sync_cnt_d   = '0;
      err_count_d  = '0;
      word_count_d = '0;
      ready_d      = 1'b1;
      locked_d     = 1'b0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (accept) begin
            if (seed_zero) begin
              // An all-zero seed would lock the LFSR at zero, so it is never loaded.
              sync_cnt_d = '0;
            end else begin
              sync_cnt_d   = (have_pred_q && word_match) ? sync_cnt_q + 1'b1 : '0;
              pred_state_d = i_data[6:0];
              have_pred_d  = 1'b1;
            end
            if (sync_cnt_d == SYNC_LEN_C) begin
              state_d  = ST_CHECK;
              locked_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (accept) begin
            word_count_d = word_count_q + 1'b1;
            if (!word_match && (err_count_q != '1)) begin
              err_count_d = err_count_q + 1'b1;
            end
            pred_state_d = pred_word[6:0];
            if (word_count_d == NUM_WORDS_C) begin
              state_d = ST_DONE;
              ready_d = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_count_d == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      pred_state_q <= PRBS_SEED;
      have_pred_q  <= 1'b0;
      sync_cnt_q   <= '0;
      err_count_q  <= '0;
      word_count_q <= '0;
      ready_q      <= 1'b0;
      locked_q     <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pred_state_q <= pred_state_d;
      have_pred_q  <= have_pred_d;
      sync_cnt_q   <= sync_cnt_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
      ready_q      <= ready_d;
      locked_q     <= locked_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_locked     = locked_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_err_count  = err_count_q;
  assign o_word_count = word_count_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Bench for prbs_stream_checker: recurrence-based PRBS7 reference model checked every cycle,
// plus directed end-of-run checks for lock, single error, zero seed, gaps, saturation and reset.
module tb_prbs_stream_checker;

  localparam int SL   = 4;
  localparam int NW   = 256;
  localparam int NW_B = 32;

  localparam int P_IDLE  = 0;
  localparam int P_SYNC  = 1;
  localparam int P_CHECK = 2;
  localparam int P_DONE  = 3;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data  = 8'h00;

  logic        a_ready, a_locked, a_done, a_pass;
  logic [15:0] a_err, a_wc;
  logic [1:0]  a_dbg;
  logic        b_ready, b_locked, b_done, b_pass;
  logic [3:0]  b_err;
  logic [15:0] b_wc;
  logic [1:0]  b_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 i_clk = ~i_clk;

  prbs_stream_checker #(.WIDTH(8), .SYNC_LEN(SL), .NUM_WORDS(NW), .ERR_W(16)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (a_ready),
    .o_locked     (a_locked),
    .o_done       (a_done),
    .o_pass       (a_pass),
    .o_err_count  (a_err),
    .o_word_count (a_wc),
    .o_dbg_state  (a_dbg)
  );

  prbs_stream_checker #(.WIDTH(8), .SYNC_LEN(SL), .NUM_WORDS(NW_B), .ERR_W(4)) dut_sat (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (b_ready),
    .o_locked     (b_locked),
    .o_done       (b_done),
    .o_pass       (b_pass),
    .o_err_count  (b_err),
    .o_word_count (b_wc),
    .o_dbg_state  (b_dbg)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // PRBS7 as a bit recurrence: h[n] = h[n-7] ^ h[n-6], history seeded MSB-first from the 7-bit state.
  function automatic logic [7:0] prbs_word_after(input logic [6:0] seed);
    bit h[0:14];
    logic [7:0] w;
    for (int i = 0; i < 7; i++) h[i] = seed[6-i];
    for (int n = 7; n < 15; n++) h[n] = h[n-7] ^ h[n-6];
    for (int k = 0; k < 8; k++) w[7-k] = h[7+k];
    return w;
  endfunction

  // Reference model of the main checker, kept as run phase plus plain counters.
  int         m_phase  = P_IDLE;
  logic [6:0] m_seed   = 7'h7F;
  bit         m_have   = 0;
  int         m_streak = 0;
  int         m_errs   = 0;
  int         m_words  = 0;

  function automatic bit m_ready();
    return (m_phase == P_SYNC) || (m_phase == P_CHECK);
  endfunction

  always @(posedge i_clk or negedge i_reset) begin
    logic [7:0] exp_w;
    if (!i_reset) begin
      m_phase = P_IDLE; m_seed = 7'h7F; m_have = 0;
      m_streak = 0; m_errs = 0; m_words = 0;
    end else if (i_start) begin
      m_phase = P_SYNC; m_have = 0; m_streak = 0; m_errs = 0; m_words = 0;
    end else if (i_valid && m_ready()) begin
      exp_w = prbs_word_after(m_seed);
      if (m_phase == P_SYNC) begin
        if (i_data[6:0] == 7'd0) begin
          m_streak = 0;
        end else begin
          m_streak = (m_have && i_data == exp_w) ? m_streak + 1 : 0;
          m_seed   = i_data[6:0];
          m_have   = 1;
        end
        if (m_streak == SL) m_phase = P_CHECK;
      end else begin
        m_words++;
        if (i_data != exp_w) m_errs++;
        m_seed = exp_w[6:0];
        if (m_words == NW) m_phase = P_DONE;
      end
    end
  end

  always @(negedge i_clk) begin
    check("cyc_ready",  {31'd0, a_ready},  {31'd0, m_ready()});
    check("cyc_locked", {31'd0, a_locked}, {31'd0, (m_phase == P_CHECK || m_phase == P_DONE)});
    check("cyc_done",   {31'd0, a_done},   {31'd0, (m_phase == P_DONE)});
    check("cyc_pass",   {31'd0, a_pass},   {31'd0, (m_phase == P_DONE && m_errs == 0)});
    check("cyc_err",    {16'd0, a_err},    (m_errs > 65535) ? 32'hFFFF : m_errs);
    check("cyc_wc",     {16'd0, a_wc},     m_words & 32'hFFFF);
  end

  // Drivers start and end on a falling edge; a word is offered until the main checker takes it.
  task automatic send_word(input logic [7:0] w, input int gap);
    logic acc;
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'b0;
      i_data  = 8'($urandom_range(0, 255));
      @(negedge i_clk);
    end
    i_valid = 1'b1;
    i_data  = w;
    for (int t = 0; t < 60; t++) begin
      acc = a_ready;
      @(negedge i_clk);
      if (acc) break;
      if (t == 59) check("send_timeout", {31'd0, acc}, 32'd1);
    end
    i_valid = 1'b0;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    i_valid = 1'($urandom_range(0, 1));
    i_data  = 8'($urandom_range(0, 255));
    @(negedge i_clk);
    i_start = 1'b0;
    i_valid = 1'b0;
  endtask

  // Sync preamble FF + SL golden words, then n_check words; flip_idx or garbage inverts words.
  task automatic run_stream(input int flip_idx, input int gap_max, input int n_check, input bit garbage);
    logic [6:0] seed;
    logic [7:0] w;
    seed = 7'h7F;
    send_word(8'hFF, 0);
    for (int i = 0; i < SL; i++) begin
      w = prbs_word_after(seed);
      seed = w[6:0];
      send_word(w, $urandom_range(0, gap_max));
    end
    for (int i = 0; i < n_check; i++) begin
      w = prbs_word_after(seed);
      seed = w[6:0];
      send_word((garbage || i == flip_idx) ? ~w : w, $urandom_range(0, gap_max));
      if (garbage && i == 20) check("sat_err_mid", {28'd0, b_err}, 32'd15);
    end
  endtask

  task automatic check_final(input string tag, input logic [15:0] err, input logic pass);
    check({tag, "_done"},  {31'd0, a_done},  32'd1);
    check({tag, "_ready"}, {31'd0, a_ready}, 32'd0);
    check({tag, "_pass"},  {31'd0, a_pass},  {31'd0, pass});
    check({tag, "_err"},   {16'd0, a_err},   {16'd0, err});
    check({tag, "_wc"},    {16'd0, a_wc},    32'd256);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_ready",  {31'd0, a_ready},  32'd0);
    check("rst_locked", {31'd0, a_locked}, 32'd0);
    check("rst_done",   {31'd0, a_done},   32'd0);
    check("rst_pass",   {31'd0, a_pass},   32'd0);
    check("rst_err",    {16'd0, a_err},    32'd0);
    check("rst_wc",     {16'd0, a_wc},     32'd0);
    check("pin_7f", {24'd0, prbs_word_after(7'h7F)}, 32'h02);
    check("pin_02", {24'd0, prbs_word_after(7'h02)}, 32'h0C);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Clean back-to-back run
    start_pulse();
    check("t1_ready_after_start", {31'd0, a_ready}, 32'd1);
    run_stream(-1, 0, NW, 1'b0);
    check_final("t1", 16'd0, 1'b1);

    // Single flipped word in CHECK
    start_pulse();
    run_stream(9, 0, NW, 1'b0);
    check_final("t2", 16'd1, 1'b0);

    // Zero-seed word during SYNC
    start_pulse();
    send_word(8'hFF, 0);
    send_word(8'h02, 0);
    send_word(8'h80, 0);
    check("t3_not_locked", {31'd0, a_locked}, 32'd0);
    run_stream(-1, 0, NW, 1'b0);
    check_final("t3", 16'd0, 1'b1);

    // Random gaps between words
    start_pulse();
    run_stream(-1, 2, NW, 1'b0);
    check_final("t4", 16'd0, 1'b1);

    // All-garbage check phase; ERR_W=4 instance saturates
    start_pulse();
    run_stream(-1, 0, 40, 1'b1);
    check("sat_err",     {28'd0, b_err},   32'd15);
    check("sat_wc",      {16'd0, b_wc},    32'd32);
    check("sat_done",    {31'd0, b_done},  32'd1);
    check("sat_pass",    {31'd0, b_pass},  32'd0);
    check("t5_main_err", {16'd0, a_err},   32'd40);
    check("t5_locked",   {31'd0, a_locked}, 32'd1);

    // Asynchronous reset in the middle of CHECK
    #2 i_reset = 1'b0;
    #1;
    check("arst_ready",  {31'd0, a_ready},  32'd0);
    check("arst_locked", {31'd0, a_locked}, 32'd0);
    check("arst_err",    {16'd0, a_err},    32'd0);
    check("arst_wc",     {16'd0, a_wc},     32'd0);
    check("arst_b_err",  {28'd0, b_err},    32'd0);
    repeat (2) @(negedge i_clk);
    #2 i_reset = 1'b1;
    @(negedge i_clk);
    start_pulse();
    run_stream(-1, 0, NW, 1'b0);
    check_final("t6", 16'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
